// File: rtl/sram_resp_pkg.sv
// Shared constants and helpers for the data-SRAM responder: MMIO register
// offsets within the 64 KiB window and the byte-lane merge used by every
// writable location.
package sram_resp_pkg;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_TIMER   = 16'h0004;
    localparam logic [15:0] OFF_SCRATCH = 16'h0008;

    // Replace the bytes of old_word whose enable bit is set with the
    // corresponding bytes of new_word; unselected bytes pass through.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port synchronous RAM with four byte lanes, read-first behaviour and
// a registered output. Written in the plain shape synthesis tools map to a
// block RAM.
module sram_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    logic [31:0] mem [2**ADDR_W];

    // Byte-lane writes into the array.
    // NOTE: the array itself has no reset; clearing it would prevent block-RAM
    // mapping, and software never relies on RAM contents after reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port: captures the pre-write word (read-first) and holds when idle.
    // NOTE: non-blocking assignment here is what makes the read see the old
    // word even though the write above lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the CPU data-SRAM port. Every access returns its read data
// exactly one cycle later with no back-pressure. Addresses whose upper half
// equals MMIO_HI reach a small register window (LED, free-running timer,
// scratch); everything else goes to a word-addressed RAM that aliases on the
// unused upper address bits.
module data_sram_responder
    import sram_resp_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] MMIO_HI = 16'hBFAF,
    parameter int          LED_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic [LED_W-1:0] led
);

    logic              mmio_sel;
    logic [15:0]       mmio_off;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;
    logic              sel_mmio_q;
    logic [31:0]       mmio_q;
    logic [31:0]       mmio_rd;
    logic [31:0]       timer_q;
    logic [31:0]       scratch_q;
    logic [31:0]       led_ext;
    logic [31:0]       led_wr;
    logic              mmio_wr;
    logic              unused_addr_lsb;

    assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
    // Byte offset inside the window with the two byte-select bits dropped.
    assign mmio_off = {data_sram_addr[15:2], 2'b00};
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Writes presented during reset are discarded for both RAM and MMIO.
    assign ram_en  = data_sram_en & ~mmio_sel;
    assign ram_we  = (ram_en & ~rst) ? data_sram_wen : 4'b0000;
    assign mmio_wr = data_sram_en & mmio_sel & (|data_sram_wen);

    sram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (data_sram_addr[ADDR_W+1:2]),
        .wdata (data_sram_wdata),
        .q     (ram_q)
    );

    // Zero-extend the LED register to a full word for reads and lane merging.
    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        led_ext            = '0;
        led_ext[LED_W-1:0] = led;
    end

    assign led_wr = merge_bytes(led_ext, data_sram_wdata, data_sram_wen);

    // MMIO read mux: current register values, unmapped offsets read as zero.
    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            OFF_LED:     mmio_rd = led_ext;
            OFF_TIMER:   mmio_rd = timer_q;
            OFF_SCRATCH: mmio_rd = scratch_q;
            default:     mmio_rd = '0;
        endcase
    end

    // LED register: byte-lane writes, only the low LED_W bits are stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else if (mmio_wr && mmio_off == OFF_LED) begin
            led <= led_wr[LED_W-1:0];
        end
    end

    // Free-running timer; written lanes take the write data, the rest take
    // this cycle's incremented value.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (mmio_wr && mmio_off == OFF_TIMER) begin
            timer_q <= merge_bytes(timer_q + 32'd1, data_sram_wdata, data_sram_wen);
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Scratch register: plain byte-lane read/write storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= '0;
        end else if (mmio_wr && mmio_off == OFF_SCRATCH) begin
            scratch_q <= merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
        end
    end

    // Capture the MMIO read value and the RAM/MMIO select alongside the bank
    // output so the final mux lines up with the one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_q     <= '0;
            sel_mmio_q <= 1'b0;
        end else if (data_sram_en) begin
            sel_mmio_q <= mmio_sel;
            if (mmio_sel) begin
                mmio_q <= mmio_rd;
            end
        end
    end

    assign data_sram_rdata = sel_mmio_q ? mmio_q : ram_q;

endmodule
